// File: rtl/rgb_pixel_packer.sv
// -----------------------------------------------------------------------------
// rgb_pixel_packer
//
// Output stage behind the ISP top. The ISP emits one colour component per beat
// (RED, GREEN, BLUE, in that order). This block gathers each R,G,B triplet into
// one 24-bit {R,G,B} word and queues it in a small FIFO. A valid/ready master
// port hands the queued words to the frame writer. The block also flags
// components that arrive out of order and packed words that are lost because
// the FIFO is full.
//
// Ports
//   clk          in   1      clock, rising edge
//   rst_n        in   1      asynchronous reset, active low
//   pixel_in     in   8      component value
//   valid_in     in   1      component beat valid; upstream cannot be stalled
//   color_in     in   2      component colour (RED/GREEN/BLUE/VOID)
//   last_col_in  in   1      component belongs to the last column of a row
//   last_pic_in  in   1      component belongs to the last pixel of the frame
//   clear_err    in   1      synchronous pulse; clears seq_err and overflow
//   m_data       out  24     {R,G,B} word at the FIFO head (0 while empty)
//   m_last_col   out  1      head word ends a row
//   m_last_pic   out  1      head word ends the frame
//   m_valid      out  1      FIFO not empty
//   m_ready      in   1      consumer takes the head when m_valid & m_ready
//   frame_done   out  1      1-cycle pulse after the last_pic word is popped
//   pix_count    out  CNT_W  words popped in the current frame, saturating
//   seq_err      out  1      sticky: a component arrived out of order
//   overflow     out  1      sticky: a packed word was dropped on a full FIFO
//
// Colour encoding: RED=0, GREEN=1, BLUE=2, VOID=3.
//
// Assembler states
//   state | meaning
//   EXP_R | waiting for the RED component of a new triplet
//   EXP_G | RED held, waiting for GREEN
//   EXP_B | RED and GREEN held, waiting for BLUE
// -----------------------------------------------------------------------------
module rgb_pixel_packer #(
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       pixel_in,
  input  logic             valid_in,
  input  logic [1:0]       color_in,
  input  logic             last_col_in,
  input  logic             last_pic_in,
  input  logic             clear_err,
  output logic [23:0]      m_data,
  output logic             m_last_col,
  output logic             m_last_pic,
  output logic             m_valid,
  input  logic             m_ready,
  output logic             frame_done,
  output logic [CNT_W-1:0] pix_count,
  output logic             seq_err,
  output logic             overflow
);

  localparam logic [1:0] COLOR_RED   = 2'd0;
  localparam logic [1:0] COLOR_GREEN = 2'd1;
  localparam logic [1:0] COLOR_BLUE  = 2'd2;
  localparam logic [1:0] COLOR_VOID  = 2'd3;

  localparam int AW = $clog2(FIFO_DEPTH);

  localparam logic [AW:0]      PTR_ONE = {{AW{1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    EXP_R = 2'd0,
    EXP_G = 2'd1,
    EXP_B = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // Triplet assembler
  // ---------------------------------------------------------------------------
  state_t      r_state;
  state_t      w_state_nxt;
  logic [7:0]  r_red;
  logic [7:0]  r_green;
  logic        r_col_acc;
  logic        r_pic_acc;

  logic        w_beat;
  logic        w_ld_r;
  logic        w_ld_g;
  logic        w_push_req;
  logic        w_ord_err;
  logic [25:0] w_word;

  assign w_beat = valid_in && (color_in != COLOR_VOID);

  always_comb begin
    w_state_nxt = r_state;
    w_ld_r      = 1'b0;
    w_ld_g      = 1'b0;
    w_push_req  = 1'b0;
    w_ord_err   = 1'b0;
    if (w_beat) begin
      case (r_state)
        EXP_R: begin
          if (color_in == COLOR_RED) begin
            w_ld_r      = 1'b1;
            w_state_nxt = EXP_G;
          end else begin
            w_ord_err   = 1'b1;
            w_state_nxt = EXP_R;
          end
        end
        EXP_G: begin
          if (color_in == COLOR_GREEN) begin
            w_ld_g      = 1'b1;
            w_state_nxt = EXP_B;
          end else if (color_in == COLOR_RED) begin
            // A stray RED restarts the triplet with itself as the new R.
            w_ord_err   = 1'b1;
            w_ld_r      = 1'b1;
            w_state_nxt = EXP_G;
          end else begin
            w_ord_err   = 1'b1;
            w_state_nxt = EXP_R;
          end
        end
        EXP_B: begin
          if (color_in == COLOR_BLUE) begin
            w_push_req  = 1'b1;
            w_state_nxt = EXP_R;
          end else if (color_in == COLOR_RED) begin
            w_ord_err   = 1'b1;
            w_ld_r      = 1'b1;
            w_state_nxt = EXP_G;
          end else begin
            w_ord_err   = 1'b1;
            w_state_nxt = EXP_R;
          end
        end
        default: begin
          w_state_nxt = EXP_R;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= EXP_R;
      r_red     <= 8'd0;
      r_green   <= 8'd0;
      r_col_acc <= 1'b0;
      r_pic_acc <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      // Loading R starts a fresh triplet, so the flags restart from this beat.
      if (w_ld_r) begin
        r_red     <= pixel_in;
        r_col_acc <= last_col_in;
        r_pic_acc <= last_pic_in;
      end
      if (w_ld_g) begin
        r_green   <= pixel_in;
        r_col_acc <= r_col_acc | last_col_in;
        r_pic_acc <= r_pic_acc | last_pic_in;
      end
    end
  end

  // BLUE is never registered: it goes straight into the FIFO entry together
  // with the held R and G.
  assign w_word = {r_red, r_green, pixel_in,
                   r_col_acc | last_col_in,
                   r_pic_acc | last_pic_in};

  // ---------------------------------------------------------------------------
  // Packed-word FIFO
  // ---------------------------------------------------------------------------
  logic [25:0] r_mem [FIFO_DEPTH];
  logic [AW:0] r_wr_ptr;
  logic [AW:0] r_rd_ptr;

  logic        w_empty;
  logic        w_full;
  logic        w_pop;
  logic        w_push;
  logic        w_drop;
  logic [25:0] w_head;

  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_pop   = !w_empty && m_ready;
  // A pop in the same cycle frees the slot the push needs.
  assign w_push  = w_push_req && (!w_full || w_pop);
  assign w_drop  = w_push_req && w_full && !w_pop;
  assign w_head  = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr[AW-1:0]] <= w_word;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
    end
  end

  // Head fields are masked while empty so the port never shows stale words.
  assign m_valid    = !w_empty;
  assign m_data     = m_valid ? w_head[25:2] : 24'd0;
  assign m_last_col = m_valid & w_head[1];
  assign m_last_pic = m_valid & w_head[0];

  // ---------------------------------------------------------------------------
  // Frame accounting and sticky status
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] r_pix_count;
  logic             r_frame_done;
  logic             r_seq_err;
  logic             r_overflow;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pix_count  <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= w_pop && w_head[0];
      if (w_pop) begin
        if (w_head[0]) begin
          r_pix_count <= '0;
        end else if (r_pix_count != '1) begin
          r_pix_count <= r_pix_count + CNT_ONE;
        end
      end
    end
  end

  // A new error in the same cycle as clear_err takes priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_seq_err  <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      if (w_ord_err) begin
        r_seq_err <= 1'b1;
      end else if (clear_err) begin
        r_seq_err <= 1'b0;
      end
      if (w_drop) begin
        r_overflow <= 1'b1;
      end else if (clear_err) begin
        r_overflow <= 1'b0;
      end
    end
  end

  assign pix_count  = r_pix_count;
  assign frame_done = r_frame_done;
  assign seq_err    = r_seq_err;
  assign overflow   = r_overflow;

endmodule

// File: tb/tb_rgb_pixel_packer.sv
module tb_rgb_pixel_packer;

  localparam int DEPTH = 8;
  localparam logic [1:0] C_RED   = 2'd0;
  localparam logic [1:0] C_GREEN = 2'd1;
  localparam logic [1:0] C_BLUE  = 2'd2;
  localparam logic [1:0] C_VOID  = 2'd3;

  logic        clk;
  logic        rst_n;
  logic [7:0]  pixel_in;
  logic        valid_in;
  logic [1:0]  color_in;
  logic        last_col_in;
  logic        last_pic_in;
  logic        clear_err;
  logic [23:0] m_data;
  logic        m_last_col;
  logic        m_last_pic;
  logic        m_valid;
  logic        m_ready;
  logic        frame_done;
  logic [15:0] pix_count;
  logic        seq_err;
  logic        overflow;

  rgb_pixel_packer #(.FIFO_DEPTH(DEPTH), .CNT_W(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pixel_in    (pixel_in),
    .valid_in    (valid_in),
    .color_in    (color_in),
    .last_col_in (last_col_in),
    .last_pic_in (last_pic_in),
    .clear_err   (clear_err),
    .m_data      (m_data),
    .m_last_col  (m_last_col),
    .m_last_pic  (m_last_pic),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .frame_done  (frame_done),
    .pix_count   (pix_count),
    .seq_err     (seq_err),
    .overflow    (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_chk++;
    if (obs === exp_v) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp_v, $time);
  endtask

  // Reference model: components collected so far, and the FIFO as a queue.
  typedef struct packed {
    logic [23:0] d;
    logic        col;
    logic        pic;
  } word_t;

  logic [7:0]  part[$];
  logic        acc_col, acc_pic;
  word_t       fq[$];
  logic        exp_seq, exp_ovf, exp_fd;
  logic [15:0] exp_pc;

  task automatic model_reset();
    part.delete();
    fq.delete();
    acc_col = 0; acc_pic = 0;
    exp_seq = 0; exp_ovf = 0; exp_fd = 0; exp_pc = 0;
  endtask

  task automatic model_edge();
    bit pop, push, err, ovf_set;
    word_t hw, nw;
    pop = (fq.size() > 0) && m_ready;
    push = 0; err = 0; ovf_set = 0; hw = '0; nw = '0;
    if (pop) hw = fq[0];
    if (valid_in && color_in != C_VOID) begin
      // Colour codes 0,1,2 equal the number of components already collected.
      if (int'(color_in) == part.size()) begin
        if (part.size() == 0) begin
          acc_col = last_col_in; acc_pic = last_pic_in;
        end else begin
          acc_col = acc_col | last_col_in; acc_pic = acc_pic | last_pic_in;
        end
        part.push_back(pixel_in);
        if (part.size() == 3) begin
          nw.d = {part[0], part[1], part[2]};
          nw.col = acc_col; nw.pic = acc_pic;
          part.delete();
          push = 1;
        end
      end else begin
        err = 1;
        part.delete();
        if (color_in == C_RED) begin
          part.push_back(pixel_in);
          acc_col = last_col_in; acc_pic = last_pic_in;
        end
      end
    end
    if (push && fq.size() == DEPTH && !pop) ovf_set = 1;
    if (pop) void'(fq.pop_front());
    if (push && !ovf_set) fq.push_back(nw);
    exp_seq = err ? 1'b1 : (clear_err ? 1'b0 : exp_seq);
    exp_ovf = ovf_set ? 1'b1 : (clear_err ? 1'b0 : exp_ovf);
    exp_fd = pop && hw.pic;
    if (pop) exp_pc = hw.pic ? 16'd0 : ((exp_pc == 16'hFFFF) ? exp_pc : exp_pc + 16'd1);
  endtask

  task automatic check_all();
    chk("m_valid", m_valid, fq.size() > 0);
    if (fq.size() > 0) begin
      chk("m_data", m_data, fq[0].d);
      chk("m_last_col", m_last_col, fq[0].col);
      chk("m_last_pic", m_last_pic, fq[0].pic);
    end
    chk("pix_count", pix_count, exp_pc);
    chk("frame_done", frame_done, exp_fd);
    chk("seq_err", seq_err, exp_seq);
    chk("overflow", overflow, exp_ovf);
  endtask

  // One clock: inputs are already driven (clock low), model follows the edge,
  // outputs are compared on the falling edge.
  task automatic cyc();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  task automatic idle(input int n);
    valid_in = 0; clear_err = 0;
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic beat(input logic [1:0] c, input logic [7:0] p,
                      input logic lc, input logic lp);
    valid_in = 1; color_in = c; pixel_in = p;
    last_col_in = lc; last_pic_in = lp; clear_err = 0;
    cyc();
    valid_in = 0; last_col_in = 0; last_pic_in = 0;
  endtask

  task automatic triplet(input logic [23:0] w, input logic lc, input logic lp);
    beat(C_RED, w[23:16], 0, 0);
    beat(C_GREEN, w[15:8], 0, 0);
    beat(C_BLUE, w[7:0], lc, lp);
  endtask

  task automatic pulse_clear();
    clear_err = 1; valid_in = 0;
    cyc();
    clear_err = 0;
  endtask

  task automatic do_reset();
    rst_n = 0;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1;
  endtask

  int cnt;
  int fd_cnt;
  logic cols[16];
  logic pics[16];

  initial begin
    rst_n = 0; pixel_in = 0; valid_in = 0; color_in = C_VOID;
    last_col_in = 0; last_pic_in = 0; clear_err = 0; m_ready = 0;
    model_reset();
    @(negedge clk);
    do_reset();
    idle(1);
    chk("rst_pix_count", pix_count, 16'd0);

    // Reset mid-triplet with three words queued
    m_ready = 0;
    for (int i = 0; i < 3; i++) triplet(24'hA0B0C0 + 24'(i), 0, 0);
    beat(C_RED, 8'h77, 0, 0);
    beat(C_GREEN, 8'h88, 0, 0);
    #2 rst_n = 0;
    model_reset();
    #1;
    chk("rst_m_valid", m_valid, 1'b0);
    chk("rst_m_data", m_data, 24'd0);
    chk("rst_flags", {m_last_col, m_last_pic, frame_done, seq_err, overflow}, 5'd0);
    chk("rst_pix_cnt", pix_count, 16'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    m_ready = 1;
    beat(C_GREEN, 8'h88, 0, 0);
    beat(C_BLUE, 8'h99, 0, 0);
    idle(1);
    chk("stale_seq_err", seq_err, 1'b1);
    chk("stale_no_word", m_valid, 1'b0);
    pulse_clear();
    chk("clear_seq_err", seq_err, 1'b0);

    // Basic triplet, one-cycle latency
    beat(C_RED, 8'h10, 0, 0);
    beat(C_GREEN, 8'h20, 0, 0);
    chk("basic_not_yet", m_valid, 1'b0);
    beat(C_BLUE, 8'h30, 0, 0);
    chk("basic_valid", m_valid, 1'b1);
    chk("basic_data", m_data, 24'h102030);
    idle(1);
    chk("basic_1wide", m_valid, 1'b0);
    chk("basic_pix_count", pix_count, 16'd1);

    // Order error
    beat(C_RED, 8'h11, 0, 0);
    beat(C_BLUE, 8'h33, 0, 0);
    beat(C_RED, 8'h44, 0, 0);
    beat(C_GREEN, 8'h55, 0, 0);
    beat(C_BLUE, 8'h66, 0, 0);
    chk("order_seq_err", seq_err, 1'b1);
    chk("order_data", m_data, 24'h445566);
    idle(2);
    pulse_clear();

    // Backpressure and overflow
    m_ready = 0;
    for (int i = 0; i <= DEPTH; i++) triplet({8'h50 + 8'(i), 8'h60 + 8'(i), 8'h70 + 8'(i)}, 0, 0);
    chk("bp_overflow", overflow, 1'b1);
    chk("bp_head", m_data, 24'h506070);
    m_ready = 1;
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      if (m_valid) cnt++;
      idle(1);
    end
    chk("bp_drain_cnt", cnt, DEPTH);
    pulse_clear();
    chk("bp_ovf_cleared", overflow, 1'b0);

    // 4x2 frame
    do_reset();
    m_ready = 0;
    for (int i = 0; i < 8; i++)
      triplet({8'(i), 8'(i) + 8'h40, 8'(i) + 8'h80}, (i % 4) == 3, i == 7);
    m_ready = 1;
    cnt = 0; fd_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      if (m_valid && cnt < 16) begin
        cols[cnt] = m_last_col; pics[cnt] = m_last_pic; cnt++;
      end
      idle(1);
      if (frame_done) fd_cnt++;
    end
    chk("frame_words", cnt, 8);
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("frame_col%0d", k), cols[k], (k == 3) || (k == 7));
      chk($sformatf("frame_pic%0d", k), pics[k], k == 7);
    end
    chk("frame_done_cnt", fd_cnt, 1);
    chk("frame_pix_count", pix_count, 16'd0);

    // Full FIFO with push and pop in the same cycle
    m_ready = 0;
    for (int i = 0; i < DEPTH; i++) triplet({8'hC0, 8'h00, 8'(i)}, 0, 0);
    beat(C_RED, 8'hEE, 0, 0);
    beat(C_GREEN, 8'hEF, 0, 0);
    m_ready = 1;
    beat(C_BLUE, 8'hF0, 0, 0);
    chk("fullpop_no_ovf", overflow, 1'b0);
    chk("fullpop_next", m_data, 24'hC00001);
    idle(DEPTH + 2);
    chk("fullpop_empty", m_valid, 1'b0);

    // Randomised traffic against the model
    for (int i = 0; i < 3000; i++) begin
      valid_in = ($urandom_range(3) != 0);
      if ($urandom_range(7) != 0) color_in = 2'(part.size());
      else color_in = 2'($urandom_range(3));
      pixel_in = 8'($urandom);
      last_col_in = ($urandom_range(5) == 0);
      last_pic_in = ($urandom_range(15) == 0);
      m_ready = ($urandom_range(2) != 0);
      clear_err = ($urandom_range(19) == 0);
      cyc();
    end
    idle(2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
